// File: rtl/adder_pkg.sv
// Shared definitions for the adder family: FSM state encoding and the
// default operand width used by serial and future parallel adders.
package adder_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADD  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int ADDER_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_ADD  = ST_ADD,
        S_DONE = ST_DONE
    } adder_state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder built from two half_adder cells; the two partial
// carries can never both be set, so a plain OR merges them.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic s1;
    logic c1;
    logic c2;

    half_adder u_ha0 (
        .a    (a),
        .b    (b),
        .sum  (s1),
        .cout (c1)
    );

    half_adder u_ha1 (
        .a    (s1),
        .b    (cin),
        .sum  (sum),
        .cout (c2)
    );

    assign cout = c1 | c2;

endmodule

// File: rtl/half_adder.sv
// Existing one-bit half adder cell of the adder family.
module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b;
    assign cout = a & b;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: one full-adder slice, LSB first, one bit per
// clock, producing {cout,sum} = a + b after WIDTH cycles of ADD.
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Handshake: start is sampled only in IDLE or DONE; an accepted start
    // captures a/b on that edge. done pulses for one cycle when sum/cout
    // become valid, and they then hold until the next completion.
    adder_state_t     state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sr;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             fa_s;
    logic             fa_c;

    full_adder u_fa (
        .a    (sa[0]),
        .b    (sb[0]),
        .cin  (carry),
        .sum  (fa_s),
        .cout (fa_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            sa    <= '0;
            sb    <= '0;
            sr    <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        carry <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= S_ADD;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_ADD: begin
                    sr    <= {fa_s, sr[WIDTH-1:1]};
                    sa    <= sa >> 1;
                    sb    <= sb >> 1;
                    carry <= fa_c;
                    cnt   <= cnt + CNT_W'(1);
                    // Last bit: publish the result built from this cycle's slice output.
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        sum   <= {fa_s, sr[WIDTH-1:1]};
                        cout  <= fa_c;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8): expected sums are queued when a
// start is driven and popped when the done pulse arrives.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    logic [W:0]   exp_q[$];
    logic [W:0]   prev_res;
    logic [W:0]   exp_v;
    int           n_cmp;
    int           n_err;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one operation from the current cycle and ends in its DONE cycle.
    task automatic do_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input bit hold, input logic [W-1:0] ma, input logic [W-1:0] mb);
        a     = ta;
        b     = tb_v;
        start = 1'b1;
        exp_q.push_back({1'b0, ta} + {1'b0, tb_v});
        step();
        if (hold) begin
            a = ma;
            b = mb;
        end else begin
            start = 1'b0;
            a = W'($urandom_range(0, 255));
            b = W'($urandom_range(0, 255));
        end
        for (int k = 0; k < W; k++) begin
            check({tag, "_busy"}, 32'(busy), 32'd1);
            check({tag, "_nodone"}, 32'(done), 32'd0);
            check({tag, "_hold"}, 32'({cout, sum}), 32'(prev_res));
            step();
        end
        start = 1'b0;
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy_off"}, 32'(busy), 32'd0);
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 32'(exp_q.size()), 32'd1);
        end else begin
            exp_v = exp_q.pop_front();
            check({tag, "_result"}, 32'({cout, sum}), 32'(exp_v));
            prev_res = exp_v;
        end
    endtask

    task automatic idle_check(input string tag);
        step();
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_idle_hold"}, 32'({cout, sum}), 32'(prev_res));
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        prev_res = '0;
        rst_n    = 1'b0;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        repeat (3) step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        rst_n = 1'b1;
        step();

        do_op("zero", 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
        idle_check("zero");
        do_op("ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 8'h00);
        idle_check("ff_01");
        do_op("a5_5a", 8'hA5, 8'h5A, 1'b0, 8'h00, 8'h00);
        idle_check("a5_5a");
        do_op("80_80", 8'h80, 8'h80, 1'b0, 8'h00, 8'h00);
        idle_check("80_80");

        do_op("held_start", 8'h0F, 8'h01, 1'b1, 8'h11, 8'h22);
        idle_check("held_start");

        // Second start issued in the DONE cycle of the first: no idle bubble.
        do_op("b2b_first", 8'h12, 8'h34, 1'b0, 8'h00, 8'h00);
        do_op("b2b_second", 8'h7F, 8'h01, 1'b0, 8'h00, 8'h00);
        idle_check("b2b");

        for (int r = 0; r < 4; r++) begin
            do_op("rand", W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), 1'b0, 8'h00, 8'h00);
            idle_check("rand");
        end

        // Reset during the 4th ADD cycle of FF+FF aborts with no result.
        a     = 8'hFF;
        b     = 8'hFF;
        start = 1'b1;
        exp_q.push_back(9'h1FE);
        step();
        start = 1'b0;
        repeat (3) step();
        check("abort_busy_before", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        void'(exp_q.pop_back());
        prev_res = '0;
        step();
        step();
        rst_n = 1'b1;
        for (int k = 0; k < W + 2; k++) begin
            step();
            check("abort_no_done", 32'(done), 32'd0);
            check("abort_idle", 32'(busy), 32'd0);
        end

        do_op("after_abort", 8'h03, 8'h04, 1'b0, 8'h00, 8'h00);
        idle_check("after_abort");

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
